// File: rtl/clock_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl_if
// Groups the button/tick inputs and the counter-chain control outputs of
// clock_set_ctrl. clk and rst_n stay plain ports on the controller.
//   tick_1hz  : one-cycle pulse per second
//   btn_mode  : debounced mode button level, 1 = pressed
//   btn_inc   : debounced increment button level, 1 = pressed
//   run_en    : 1 = counter chain advances on tick_1hz
//   inc_hour  : one-cycle hour increment strobe
//   inc_min   : one-cycle minute increment strobe
//   sec_clr   : one-cycle seconds clear strobe
//   sel       : 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blink     : display blink phase for the selected field
// master drives the inputs (debouncers/tick source), slave is the controller.
// ---------------------------------------------------------------------------
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       run_en;
  logic       inc_hour;
  logic       inc_min;
  logic       sec_clr;
  logic [1:0] sel;
  logic       blink;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  run_en, inc_hour, inc_min, sec_clr, sel, blink
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output run_en, inc_hour, inc_min, sec_clr, sel, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller for the seconds/minutes/hours counter chain.
// btn_mode steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. In a set state
// btn_inc produces a strobe for the selected field, with auto-repeat while
// held. An idle set state falls back to RUN after TIMEOUT_S seconds.
// All outputs are registered.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : clock_set_ctrl_if.slave (tick/buttons in, chain controls out)
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT_S    = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  clock_set_ctrl_if.slave bus
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_CW  = $clog2(REP_MAX + 1);
  localparam int TO_CW   = $clog2(TIMEOUT_S + 1);

  localparam logic [REP_CW-1:0] REP_DELAY_LD = REP_CW'(REPEAT_DELAY - 1);
  localparam logic [REP_CW-1:0] REP_RATE_LD  = REP_CW'(REPEAT_RATE - 1);
  localparam logic [TO_CW-1:0]  TO_LIMIT     = TO_CW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOUR = 2'b01,
    ST_MIN  = 2'b10,
    ST_SEC  = 2'b11
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic               btn_mode_q_r;
  logic               btn_inc_q_r;
  logic               mode_rise_s;
  logic               inc_rise_s;

  logic [REP_CW-1:0]  rep_cnt_r;
  logic [REP_CW-1:0]  rep_cnt_nxt_s;
  logic               rep_act_r;
  logic               rep_act_nxt_s;
  logic               rep_fire_s;

  logic [TO_CW-1:0]   to_cnt_r;
  logic [TO_CW-1:0]   to_cnt_nxt_s;
  logic               to_hit_s;

  logic               inc_ev_s;

  logic               run_en_r;
  logic [1:0]         sel_r;
  logic               blink_r;
  logic               inc_hour_r;
  logic               inc_min_r;
  logic               sec_clr_r;

  logic               run_en_nxt_s;
  logic [1:0]         sel_nxt_s;
  logic               blink_nxt_s;
  logic               inc_hour_nxt_s;
  logic               inc_min_nxt_s;
  logic               sec_clr_nxt_s;

  assign mode_rise_s = bus.btn_mode & ~btn_mode_q_r;
  assign inc_rise_s  = bus.btn_inc & ~btn_inc_q_r;

  // The repeat counter counts down while armed; zero with btn_inc still held
  // means the delay/rate interval has just elapsed.
  assign rep_fire_s  = rep_act_r & bus.btn_inc & (rep_cnt_r == {REP_CW{1'b0}});

  assign to_hit_s    = (state_r != ST_RUN) & (to_cnt_r == TO_LIMIT);

  // Priority: mode_rise, then timeout, then increment. RUN never strobes.
  assign inc_ev_s    = (state_r != ST_RUN) & ~mode_rise_s & ~to_hit_s &
                       (inc_rise_s | rep_fire_s);

  // Button history registers for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_mode_q_r <= 1'b0;
      btn_inc_q_r  <= 1'b0;
    end else begin
      btn_mode_q_r <= bus.btn_mode;
      btn_inc_q_r  <= bus.btn_inc;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (mode_rise_s) begin
      case (state_r)
        ST_RUN:  state_nxt_s = ST_HOUR;
        ST_HOUR: state_nxt_s = ST_MIN;
        ST_MIN:  state_nxt_s = ST_SEC;
        ST_SEC:  state_nxt_s = ST_RUN;
        default: state_nxt_s = ST_RUN;
      endcase
    end else if (to_hit_s) begin
      state_nxt_s = ST_RUN;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Auto-repeat counter next value. A mode change disarms it so a held
  // btn_inc needs a fresh press in the new field.
  always_comb begin
    rep_cnt_nxt_s = rep_cnt_r;
    rep_act_nxt_s = rep_act_r;
    if ((state_r == ST_RUN) || mode_rise_s || to_hit_s || !bus.btn_inc) begin
      rep_cnt_nxt_s = {REP_CW{1'b0}};
      rep_act_nxt_s = 1'b0;
    end else if (inc_rise_s) begin
      rep_cnt_nxt_s = REP_DELAY_LD;
      rep_act_nxt_s = 1'b1;
    end else if (rep_act_r) begin
      if (rep_cnt_r == {REP_CW{1'b0}}) begin
        rep_cnt_nxt_s = REP_RATE_LD;
      end else begin
        rep_cnt_nxt_s = rep_cnt_r - {{(REP_CW-1){1'b0}}, 1'b1};
      end
    end else begin
      rep_cnt_nxt_s = {REP_CW{1'b0}};
    end
  end

  // Inactivity timeout counter next value, saturating at the limit.
  always_comb begin
    to_cnt_nxt_s = to_cnt_r;
    if ((state_r == ST_RUN) || mode_rise_s || to_hit_s || inc_ev_s) begin
      to_cnt_nxt_s = {TO_CW{1'b0}};
    end else if (bus.tick_1hz && (to_cnt_r != TO_LIMIT)) begin
      to_cnt_nxt_s = to_cnt_r + {{(TO_CW-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_nxt_s = to_cnt_r;
    end
  end

  // Repeat and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_r <= {REP_CW{1'b0}};
      rep_act_r <= 1'b0;
      to_cnt_r  <= {TO_CW{1'b0}};
    end else begin
      rep_cnt_r <= rep_cnt_nxt_s;
      rep_act_r <= rep_act_nxt_s;
      to_cnt_r  <= to_cnt_nxt_s;
    end
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    run_en_nxt_s   = (state_nxt_s == ST_RUN);
    sel_nxt_s      = state_nxt_s;
    inc_hour_nxt_s = 1'b0;
    inc_min_nxt_s  = 1'b0;
    sec_clr_nxt_s  = 1'b0;
    blink_nxt_s    = blink_r;

    case (state_r)
      ST_HOUR: inc_hour_nxt_s = inc_ev_s;
      ST_MIN:  inc_min_nxt_s  = inc_ev_s;
      ST_SEC:  sec_clr_nxt_s  = inc_ev_s;
      default: begin
        inc_hour_nxt_s = 1'b0;
        inc_min_nxt_s  = 1'b0;
        sec_clr_nxt_s  = 1'b0;
      end
    endcase

    // Keep the field lit on entry and while it is being adjusted.
    if (state_nxt_s == ST_RUN) begin
      blink_nxt_s = 1'b0;
    end else if (state_nxt_s != state_r) begin
      blink_nxt_s = 1'b1;
    end else if (inc_ev_s) begin
      blink_nxt_s = 1'b1;
    end else if (bus.tick_1hz) begin
      blink_nxt_s = ~blink_r;
    end else begin
      blink_nxt_s = blink_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en_r   <= 1'b1;
      sel_r      <= 2'b00;
      blink_r    <= 1'b0;
      inc_hour_r <= 1'b0;
      inc_min_r  <= 1'b0;
      sec_clr_r  <= 1'b0;
    end else begin
      run_en_r   <= run_en_nxt_s;
      sel_r      <= sel_nxt_s;
      blink_r    <= blink_nxt_s;
      inc_hour_r <= inc_hour_nxt_s;
      inc_min_r  <= inc_min_nxt_s;
      sec_clr_r  <= sec_clr_nxt_s;
    end
  end

  assign bus.run_en   = run_en_r;
  assign bus.sel      = sel_r;
  assign bus.blink    = blink_r;
  assign bus.inc_hour = inc_hour_r;
  assign bus.inc_min  = inc_min_r;
  assign bus.sec_clr  = sec_clr_r;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the century clock's seconds/minutes/hours counter chain. It sequences the chain between normal running and a field-by-field set mode, driven by two debounced pushbuttons. It issues per-field increment/clear strobes with auto-repeat, a run enable for the 1 Hz chain, and a blink flag for the display. It sits between the button debouncers and the counter chain.

Parameters:
REPEAT_DELAY, 500, clk cycles btn_inc must be held after its first strobe before auto-repeat starts (>=2)
REPEAT_RATE, 100, clk cycles between auto-repeat strobes (>=2)
TIMEOUT_S, 30, tick_1hz pulses with no button activity in a set state before forced return to RUN (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tick_1hz  input  1  one-cycle pulse, once per second
btn_mode  input  1  debounced level, 1 = pressed
btn_inc  input  1  debounced level, 1 = pressed
run_en  output  1  1 = counter chain advances on tick_1hz
inc_hour  output  1  one-cycle hour-increment strobe
inc_min  output  1  one-cycle minute-increment strobe
sec_clr  output  1  one-cycle seconds-clear strobe
sel  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
blink  output  1  display blink phase for the selected field

Behaviour:
- Reset (async, rst_n=0): state RUN; run_en=1, sel=00, blink=0, all strobes 0. Internal button history regs = 0, repeat/timeout counters = 0. Reset mid-set or mid-repeat aborts immediately. Release resumes in RUN.
- Edge detect: mode_rise = btn_mode & ~btn_mode_q. inc_rise = btn_inc & ~btn_inc_q. History regs update every cycle.
- FSM, one step per mode_rise: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. sel and run_en are registered: they change the cycle after mode_rise. run_en = 1 only in RUN.
- Inc strobes are registered and assert one cycle after the generating event:
  - SET_HOUR: inc_hour
  - SET_MIN: inc_min
  - SET_SEC: sec_clr
  - RUN: btn_inc is ignored; no strobes.
- Auto-repeat in a set state:
  - inc_rise produces one strobe and loads the repeat counter.
  - If btn_inc is held REPEAT_DELAY cycles after the inc_rise cycle, another strobe is produced. Further strobes follow every REPEAT_RATE cycles while held.
  - Release clears the counter immediately, with no further strobes.
  - Counter width = $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- Simultaneous mode_rise and an inc event in the same cycle: mode wins. The inc event is discarded and the repeat counter cleared. A held btn_inc continuing into the new state produces no strobe until it is released and pressed again.
- Timeout in any set state:
  - Counter clears on mode_rise or any generated strobe. It increments on tick_1hz, saturating.
  - On reaching TIMEOUT_S, the state goes to RUN in the next cycle, with no strobe that cycle.
  - Counter is 0 in RUN.
- Blink: 0 in RUN. In a set state it toggles on each tick_1hz. It is forced to 1 on entry to any set state and on every strobe, so the field stays visible while adjusting.
- At most one of inc_hour/inc_min/sec_clr is high in any cycle. Strobes never occur in RUN.
- Field wrap-around (hour 23->0 etc.) belongs to the counter chain, not this block.

Test Plan:
- Reset then idle 5 ticks -> run_en=1, sel=00, blink=0, no strobes. btn_inc pulsed in RUN -> no strobes.
- btn_mode pressed 3 times (released between) -> sel 01, 10, 11, each one cycle after the press. 4th press -> sel=00, run_en=1.
- SET_MIN, btn_inc pressed 1 cycle -> exactly one inc_min, 1 clk wide, one cycle after the press edge. inc_hour=sec_clr=0.
- SET_HOUR, REPEAT_DELAY=8, REPEAT_RATE=4, btn_inc held 20 cycles -> inc_hour at cycle 1 after the edge, then cycles 9, 13, 17. None after release.
- SET_SEC, TIMEOUT_S=3, no buttons, 3 tick_1hz -> sel=00 after the 3rd tick. One press 1 tick earlier restarts the count.
- btn_mode and btn_inc rise together in SET_HOUR -> sel=10, no inc_hour/inc_min. Assert rst_n mid auto-repeat -> outputs go to reset values immediately.
